instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, sets the PC/address width.
REQ-002 Parameter ILEN, default 32, sets the instruction word width.
REQ-003 Parameter DEPTH, default 4, sets the queue entries; power of two, minimum 4.
REQ-004 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 fetch_rd_en  in  1  fetch stage issued an instruction-memory read this cycle.
REQ-007 fetch_pc  in  XLEN  PC of the read issued this cycle.
REQ-008 imem_rdata  in  ILEN  instruction word, valid exactly one cycle after fetch_rd_en.
REQ-009 flush  in  1  redirect from execute (same cycle as fetch branch_en); kills all wrong-path state.
REQ-010 halt  out  1  backpressure to fetch; fetch stops issuing reads while high.
REQ-011 dec_valid  out  1  head entry available to decode.
REQ-012 dec_ready  in  1  decode accepts the head entry this cycle.
REQ-013 dec_instr  out  ILEN  head instruction.
REQ-014 dec_pc  out  XLEN  head PC.
REQ-015 count  out  log2(DEPTH)+1  committed entries in the queue.
REQ-016 ovf_err  out  1  sticky error: a push was attempted while the queue was full.

Function
REQ-017 A cycle with fetch_rd_en=1 and flush=0 SHALL load the in-flight register: inflight_v=1, inflight_pc=fetch_pc; otherwise inflight_v=0.
REQ-018 A cycle with inflight_v=1 and flush=0 SHALL push {inflight_pc, imem_rdata} at the tail.
REQ-019 dec_valid SHALL equal (count != 0); dec_instr/dec_pc SHALL come from the head entry; no bypass.
REQ-020 Minimum latency: fetch_rd_en in cycle t SHALL give dec_valid=1 in cycle t+2.
REQ-021 A pop SHALL occur when dec_valid && dec_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-022 dec_ready while dec_valid=0 SHALL have no effect.
REQ-023 halt SHALL be combinational: halt = (count + inflight_v + fetch_rd_en) >= DEPTH-1, without crediting same-cycle pops; this covers the fetch stage's one-cycle registered rd_en response.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-025 flush SHALL, on the next edge, clear count, both pointers and inflight_v; in that cycle it SHALL discard any fetch_rd_en, in-flight response and pop.
REQ-026 After a flush, the first push SHALL be the fetch_rd_en of the cycle following the flush.
REQ-027 A push with count==DEPTH and no same-cycle pop SHALL be dropped, and ovf_err SHALL be set and held until reset.
REQ-028 Queue order SHALL be strictly FIFO; entries SHALL not be reordered or duplicated.

Reset
REQ-029 While rst=1: count=0, pointers=0, inflight_v=0, ovf_err=0, dec_valid=0, halt=(fetch_rd_en && DEPTH-1<=1 ? 1 : 0) (comb only).
REQ-030 Assertion of rst mid-operation SHALL discard all entries immediately (asynchronously); storage array contents need not be reset.
REQ-031 After rst deasserts, the first accepted fetch_rd_en SHALL behave per REQ-017.

Structure
REQ-032 XLEN and ILEN defaults, and the queue entry struct {pc, instr}, SHALL live in the shared core package.
REQ-033 One sub-module, fifo_sync (parameterised width/depth circular buffer with count), is natural; in-flight register, halt and flush logic stay in instr_fetch_queue.

Verification
REQ-034 Streaming: fetch_rd_en=1 at PCs 0,1,2,3 with dec_ready=1 -> dec_valid from cycle t+2, dec_pc 0,1,2,3 in order, count never exceeds 1.
REQ-035 Backpressure: dec_ready=0, continuous fetch -> halt rises once count+inflight+rd_en=3; count settles at 4; ovf_err stays 0.
REQ-036 Flush: queue holding PCs 8,9,10, flush with fetch_rd_en=1 (PC 11) -> next cycle count=0, dec_valid=0; next pushed PC is the branch target (e.g. 0x40).
REQ-037 Wrap: 10 push/pop pairs with DEPTH=4 -> pointers wrap twice, output order preserved, count stays at 1.
REQ-038 Reset mid-stream: rst pulsed with count=3 -> count=0, dec_valid=0 without a clock edge; post-reset stream starts clean.
REQ-039 Overflow: force fetch_rd_en=1 ignoring halt, dec_ready=0 -> the 5th push is dropped, ovf_err=1 and sticky.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_pkg
// Shared core definitions for the instruction fetch queue slice.
//   CORE_XLEN     : default PC / address width
//   CORE_ILEN     : default instruction word width
//   fetch_entry_t : one queue entry, {pc, instr}
// ---------------------------------------------------------------------------
package instr_fetch_queue_pkg;

  localparam int unsigned CORE_XLEN = 32;
  localparam int unsigned CORE_ILEN = 32;

  // One committed fetch: the PC that was read and the word that came back.
  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// fifo_sync
// Parameterised circular buffer with an occupancy count.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   clear_i   : synchronous clear of pointers and count (storage untouched)
//   push_i    : write wdata_i at the tail
//   pop_i     : retire the head entry (ignored while empty)
//   wdata_i   : entry to write
//   rdata_o   : head entry (valid whenever count_o != 0)
//   count_o   : number of stored entries, 0..DEPTH
//   dropped_o : a push arrived while full with no pop to make room
// ---------------------------------------------------------------------------
module fifo_sync #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     dropped_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic isFull;
  logic isEmpty;
  logic popOk;
  logic pushOk;

  // Explicit wrap keeps the pointer arithmetic obvious to a reader.
  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full buffer is only legal when the head leaves in the
  // same cycle; the freed slot is the one the write pointer points at.
  always_comb begin
    isFull    = (count_q == CW'(DEPTH));
    isEmpty   = (count_q == '0);
    popOk     = pop_i && !isEmpty;
    pushOk    = push_i && (!isFull || popOk);
    dropped_o = push_i && isFull && !popOk;
  end

  // Next-state for pointers and count; clear wins over everything.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (clear_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushOk) wrPtr_d = nextPtr(wrPtr_q);
      if (popOk)  rdPtr_d = nextPtr(rdPtr_q);
      count_d = count_q + CW'(pushOk) - CW'(popOk);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; the count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (pushOk && !clear_i) mem[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Decouples the fetch stage from decode. A read issued by fetch is tracked in
// a one-deep in-flight register; the returning word is paired with its PC and
// pushed into a FIFO whose head feeds decode.
//   clk, rst    : clock, asynchronous active-high reset
//   fetch_rd_en : fetch issued an instruction-memory read this cycle
//   fetch_pc    : PC of that read
//   imem_rdata  : instruction word, one cycle after fetch_rd_en
//   flush       : redirect; drops in-flight read, queue contents and any pop
//   halt        : backpressure to fetch (combinational)
//   dec_valid   : head entry available
//   dec_ready   : decode accepts the head entry
//   dec_instr   : head instruction
//   dec_pc      : head PC
//   count       : committed entries
//   ovf_err     : sticky, a push was lost to a full queue
// ---------------------------------------------------------------------------
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = CORE_XLEN,
  parameter int unsigned ILEN  = CORE_ILEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_rd_en,
  input  logic [XLEN-1:0]        fetch_pc,
  input  logic [ILEN-1:0]        imem_rdata,
  input  logic                   flush,
  output logic                   halt,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [ILEN-1:0]        dec_instr,
  output logic [XLEN-1:0]        dec_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = XLEN + ILEN;

  logic            inflightV_q, inflightV_d;
  logic [XLEN-1:0] inflightPc_q, inflightPc_d;
  logic            ovfErr_q, ovfErr_d;

  logic            pushReq;
  logic            popReq;
  logic            dropped;
  logic [EW-1:0]   pushEntry;
  logic [EW-1:0]   headEntry;
  logic [CW-1:0]   fifoCount;
  logic [CW:0]     demand;

  // The in-flight register remembers which PC the next imem word belongs to.
  // A flush kills both the read being issued and the response arriving.
  always_comb begin
    inflightV_d  = fetch_rd_en && !flush;
    inflightPc_d = fetch_pc;
    pushReq      = inflightV_q && !flush;
    popReq       = dec_valid && dec_ready && !flush;
    pushEntry    = {inflightPc_q, imem_rdata};
    ovfErr_d     = ovfErr_q | dropped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflightV_q  <= 1'b0;
      inflightPc_q <= '0;
      ovfErr_q     <= 1'b0;
    end else begin
      inflightV_q  <= inflightV_d;
      inflightPc_q <= inflightPc_d;
      ovfErr_q     <= ovfErr_d;
    end
  end

  fifo_sync #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (flush),
    .push_i    (pushReq),
    .pop_i     (popReq),
    .wdata_i   (pushEntry),
    .rdata_o   (headEntry),
    .count_o   (fifoCount),
    .dropped_o (dropped)
  );

  // Halt counts everything that may still land in the queue: stored entries,
  // the read in flight and the read being issued now. Pops are deliberately
  // not credited so fetch's one-cycle reaction lag can never overflow it.
  always_comb begin
    demand = {1'b0, fifoCount} + (CW+1)'(inflightV_q) + (CW+1)'(fetch_rd_en);
    halt   = (demand >= (CW+1)'(DEPTH - 1));
  end

  assign count     = fifoCount;
  assign dec_valid = (fifoCount != '0);
  assign dec_pc    = headEntry[ILEN +: XLEN];
  assign dec_instr = headEntry[ILEN-1:0];
  assign ovf_err   = ovfErr_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed bench for instr_fetch_queue with DEPTH=4. Each cycle the bench
// drives inputs just after the rising edge, lets combinational logic settle,
// compares against hand-computed values, then waits for the next edge.
// The instruction memory is modelled as instrOf(pc) returned one cycle late.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetchRdEn;
  logic [XLEN-1:0] fetchPc;
  logic [ILEN-1:0] imemRdata;
  logic            flush;
  logic            halt;
  logic            decValid;
  logic            decReady;
  logic [ILEN-1:0] decInstr;
  logic [XLEN-1:0] decPc;
  logic [2:0]      count;
  logic            ovfErr;

  int              checkCount = 0;
  int              errorCount = 0;
  logic [31:0]     lastPc = '0;

  instr_fetch_queue #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_rd_en (fetchRdEn),
    .fetch_pc    (fetchPc),
    .imem_rdata  (imemRdata),
    .flush       (flush),
    .halt        (halt),
    .dec_valid   (decValid),
    .dec_ready   (decReady),
    .dec_instr   (decInstr),
    .dec_pc      (decPc),
    .count       (count),
    .ovf_err     (ovfErr)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Safety net so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  // Drives one cycle of inputs; imem returns the word for last cycle's PC.
  task automatic applyStimulus(input logic rdEn, input logic [31:0] pc,
                               input logic fl, input logic rdy);
    imemRdata = instrOf(lastPc);
    fetchRdEn = rdEn;
    fetchPc   = pc;
    flush     = fl;
    decReady  = rdy;
    lastPc    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Head entry must carry the PC and the word the memory returned for it.
  task automatic checkHead(input string tag, input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instrOf(pc);
    checkOutput({tag, "_valid"}, 32'(decValid), 32'd1);
    checkOutput({tag, "_pc"}, decPc, e.pc);
    checkOutput({tag, "_instr"}, decInstr, e.instr);
  endtask

  initial begin
    logic [31:0] expHaltStream [6];
    logic [31:0] expHaltBp     [6];
    logic [31:0] expCountBp    [6];
    logic [31:0] expCountOvf   [7];
    logic [31:0] expOvf        [7];
    expHaltStream = '{0, 0, 1, 1, 0, 0};
    expHaltBp     = '{0, 0, 1, 1, 1, 1};
    expCountBp    = '{0, 0, 1, 2, 3, 4};
    expCountOvf   = '{0, 0, 1, 2, 3, 4, 4};
    expOvf        = '{0, 0, 0, 0, 0, 0, 1};

    // Reset state, including halt with a read requested during reset.
    rst = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(decValid), 32'd0);
    checkOutput("rst_ovf", 32'(ovfErr), 32'd0);
    checkOutput("rst_halt", 32'(halt), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Streaming: two-cycle latency, in-order delivery, count never above 1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 4, 32'(i), 1'b0, 1'b1);
      checkOutput("stream_count", 32'(count), (i >= 2) ? 32'd1 : 32'd0);
      checkOutput("stream_halt", 32'(halt), expHaltStream[i]);
      if (i >= 2) checkHead("stream_head", 32'(i - 2));
      else        checkOutput("stream_valid", 32'(decValid), 32'd0);
      tick();
    end
    // Ready while empty must not disturb anything.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("empty_ready_count", 32'(count), 32'd0);
      checkOutput("empty_ready_valid", 32'(decValid), 32'd0);
      tick();
    end

    // Backpressure: fetch keeps reading one cycle past halt; queue fills.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 4, 32'h10 + 32'(i), 1'b0, 1'b0);
      checkOutput("bp_count", 32'(count), expCountBp[i]);
      checkOutput("bp_halt", 32'(halt), expHaltBp[i]);
      tick();
    end
    checkOutput("bp_ovf", 32'(ovfErr), 32'd0);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("bp_drain_count", 32'(count), 32'(4 - j));
      checkHead("bp_drain_head", 32'h10 + 32'(j));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("bp_empty_count", 32'(count), 32'd0);
    checkOutput("bp_empty_ovf", 32'(ovfErr), 32'd0);
    tick();

    // Flush: queue holds 8,9,10; flush kills PC 11 and the queue.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i < 3, 32'd8 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'd11, 1'b1, 1'b1);
    checkOutput("flush_pre_count", 32'(count), 32'd3);
    checkHead("flush_pre_head", 32'd8);
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("flush_post_count", 32'(count), 32'd0);
    checkOutput("flush_post_valid", 32'(decValid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_no_pc11", 32'(count), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("flush_target_count", 32'(count), 32'd1);
    checkHead("flush_target_head", 32'h40);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_drained", 32'(count), 32'd0);
    tick();

    // Wrap: eleven back-to-back fetches with decode always ready.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(i < 11, 32'h100 + 32'(i), 1'b0, 1'b1);
      if (i >= 2) begin
        checkOutput("wrap_count", 32'(count), 32'd1);
        checkOutput("wrap_pc", decPc, 32'h100 + 32'(i - 2));
      end else begin
        checkOutput("wrap_count", 32'(count), 32'd0);
      end
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("wrap_end_count", 32'(count), 32'd0);
    tick();

    // Reset mid-stream: clears immediately, before any clock edge.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i < 3, 32'h200 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("mid_rst_pre_count", 32'(count), 32'd3);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_valid", 32'(decValid), 32'd0);
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 32'h280, 1'b0, 1'b0);
    checkOutput("post_rst_c0", 32'(count), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post_rst_c1", 32'(count), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("post_rst_c2", 32'(count), 32'd1);
    checkHead("post_rst_head", 32'h280);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post_rst_drained", 32'(count), 32'd0);
    tick();

    // Overflow: five reads ignoring halt, decode stalled; fifth is lost.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(i < 5, 32'h300 + 32'(i), 1'b0, 1'b0);
      checkOutput("ovf_count", 32'(count), expCountOvf[i]);
      checkOutput("ovf_flag", 32'(ovfErr), expOvf[i]);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkHead("ovf_drain_head", 32'h300 + 32'(j));
      checkOutput("ovf_sticky", 32'(ovfErr), 32'd1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_end_count", 32'(count), 32'd0);
    checkOutput("ovf_end_sticky", 32'(ovfErr), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("ovf_rst_clear", 32'(ovfErr), 32'd0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
